rx_descramb_subcarrier: RTL
===========================

RX_DESCRAMB_SUBCARRIER -- requirements
Module: rx_descramb_subcarrier

Interface
REQ-001 SHALL have parameter fft_depth, default 12, giving the I/Q sample width in bits (two's complement).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports isubc_i and isubc_q, input, fft_depth bits each: received subcarrier I/Q.
REQ-005 SHALL have port iindex_subc, input, 2 bits: subcarrier type, where 1 = data and all other values = non-data.
REQ-006 SHALL have ports index_M_in (3 bits) and index_SS_in (4 bits), inputs: side-band tags.
REQ-007 SHALL have ports isop, ival and ieop, inputs, 1 bit each: start of frame, sample valid, end of frame.
REQ-008 SHALL have ports osubc_i and osubc_q, output, fft_depth bits each: descrambled I/Q.
REQ-009 SHALL have ports oindex_subc, index_M_out, index_SS_out, osop, oval and oeop, outputs: delayed copies of the matching inputs.
REQ-010 SHALL have port odata_cnt, output, fft_depth bits: number of data subcarriers in the frame; valid on the oeop cycle.
REQ-011 SHALL have port oframe_err, output, 1 bit: one-cycle framing-error pulse, aligned with the offending output sample.

Function
REQ-012 SHALL implement a 15-bit LFSR with feedback lfsr[14]^lfsr[13], shift {lfsr[13:0],fb}, and init value 15'd23248.
REQ-013 SHALL use lfsr[0] of the current state as the mask bit for the k-th data sample of a frame, then shift once; the mask sequence from init therefore starts 0,1,1,0.
REQ-014 SHALL run an FSM with states IDLE and FRAME, and SHALL ignore all control inputs in cycles with ival=0.
REQ-015 SHALL, on an IDLE sample with ival&isop, load the LFSR with init, clear the data count and enter FRAME.
REQ-016 SHALL treat a sop sample with iindex_subc=1 as data sample k=0: mask bit = init[0] = 0, and the LFSR next state is init shifted once.
REQ-017 SHALL, in FRAME, advance the LFSR and the data count only on samples with ival=1 and iindex_subc=1.
REQ-018 SHALL return to IDLE on an ival&ieop sample.
REQ-019 SHALL treat sop&eop on the same sample as a complete one-sample frame.
REQ-020 SHALL, on ival&isop while in FRAME (missing eop), assert oframe_err on that sample and restart the frame exactly as in REQ-015.
REQ-021 SHALL, on ival with isop=0 while in IDLE (orphan sample), pass the data through unmasked, not count it, and assert oframe_err.
REQ-022 SHALL, on ival&ieop while in IDLE without isop, assert oframe_err and stay in IDLE.
REQ-023 SHALL negate both I and Q of a data sample whose mask bit is 1, and pass all other samples unchanged (including ival=0 cycles).
REQ-024 SHALL saturate negation: -(-2^(fft_depth-1)) becomes 2^(fft_depth-1)-1; no other value saturates.
REQ-025 SHALL use a two-stage pipeline (stage 1: register inputs and mask bit; stage 2: conditional saturating negate), with a fixed latency of 2 cycles for every output.
REQ-026 SHALL keep all outputs mutually aligned.
REQ-027 SHALL make odata_cnt on the oeop cycle include the eop sample when that sample is data.
REQ-028 SHALL saturate odata_cnt at all-ones and hold the last frame's count until the next eop.
REQ-029 SHALL have no backpressure; a sample is accepted on every ival cycle.

Reset
REQ-030 SHALL, while rst=1, drive all outputs to 0, set the FSM to IDLE, load the LFSR with init, clear the count, and flush both pipeline stages.
REQ-031 SHALL, on reset mid-frame, discard the frame: no oeop and no oframe_err are emitted for it, and the first valid sample after reset is handled from IDLE.
REQ-032 SHALL drive oval=0 for the first 2 cycles after rst deasserts, unless ival was high in those cycles.

Verification
REQ-033 SHALL pass: sop on pilot (idx 0, I=100), then 4 data samples I=100/Q=-5, eop on the last -> outputs I 100,100,-100,-100,100 and Q -5,-5,5,5,-5; odata_cnt=4 at oeop; latency 2.
REQ-034 SHALL pass: sop, data, data, second sop without eop -> oframe_err=1 aligned with the second osop; the next data sample uses mask 0 (LFSR restarted).
REQ-035 SHALL pass: data at mask positions k=1,2 with I=-2048 (fft_depth=12) -> output I=2047.
REQ-036 SHALL pass: ival=1, isop=0 in IDLE with idx=1, I=7 -> output I=7, oframe_err=1, odata_cnt unchanged.
REQ-037 SHALL pass: sop&eop on a single data sample I=9 -> output I=9, osop=oeop=1, odata_cnt=1.
REQ-038 SHALL pass: rst pulse after the 2nd data sample, then a new frame -> no oeop for the aborted frame; the new frame's mask starts 0,1,1,0.

Source files
------------

// File: rtl/rx_descramb_subcarrier.sv
// Receive-side subcarrier descrambler.
// Data subcarriers inside a frame are conditionally negated (with saturation)
// using a 15-bit LFSR mask that restarts on every start-of-frame. Framing
// violations are flagged on the offending output sample. Fixed two-cycle
// latency for every output; no backpressure.
//
// Handshake: a sample is transferred on every clk edge where ival=1; there is
// no ready, so isop/ieop/iindex_subc are only interpreted when ival=1. Outputs
// follow the same rule: oval=1 marks a valid output sample.
module rx_descramb_subcarrier #(
    parameter int fft_depth = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [fft_depth-1:0] isubc_i,
    input  logic [fft_depth-1:0] isubc_q,
    input  logic [1:0]           iindex_subc,
    input  logic [2:0]           index_M_in,
    input  logic [3:0]           index_SS_in,
    input  logic                 isop,
    input  logic                 ival,
    input  logic                 ieop,
    output logic [fft_depth-1:0] osubc_i,
    output logic [fft_depth-1:0] osubc_q,
    output logic [1:0]           oindex_subc,
    output logic [2:0]           index_M_out,
    output logic [3:0]           index_SS_out,
    output logic                 osop,
    output logic                 oval,
    output logic                 oeop,
    output logic [fft_depth-1:0] odata_cnt,
    output logic                 oframe_err,
    output logic                 dbg_state
);

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    localparam logic [14:0]          LFSR_INIT = 15'd23248;
    localparam logic [fft_depth-1:0] SMIN = {1'b1, {(fft_depth-1){1'b0}}};
    localparam logic [fft_depth-1:0] SMAX = {1'b0, {(fft_depth-1){1'b1}}};
    localparam logic [fft_depth-1:0] CMAX = {fft_depth{1'b1}};
    localparam logic [fft_depth-1:0] ONE  = {{(fft_depth-1){1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [14:0]          lfsr_q, lfsr_cur, lfsr_nxt;
    logic [fft_depth-1:0] cnt_q, cnt_base, cnt_nxt;
    logic                 frame_start, in_frame, is_data, mask_bit, err;

    // stage 1 registers
    logic [fft_depth-1:0] s1_i, s1_q, s1_cnt;
    logic [1:0]           s1_idx;
    logic [2:0]           s1_m;
    logic [3:0]           s1_ss;
    logic                 s1_sop, s1_val, s1_eop, s1_mask, s1_err;

    // Two's-complement negate; the most negative value clips to the maximum.
    function automatic logic [fft_depth-1:0] sat_neg(input logic [fft_depth-1:0] x);
        if (x == SMIN) return SMAX;
        return ~x + ONE;
    endfunction

    assign dbg_state = state;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: only valid samples move the machine
    always_comb begin
        state_nxt = state;
        if (ival) begin
            if (isop || state == FRAME) state_nxt = ieop ? IDLE : FRAME;
            else                        state_nxt = IDLE;
        end
    end

    // FSM outputs: mask bit, framing error, next LFSR state and data count
    always_comb begin
        frame_start = ival & isop;
        in_frame    = ival & (isop | (state == FRAME));
        is_data     = in_frame & (iindex_subc == 2'd1);
        lfsr_cur    = frame_start ? LFSR_INIT : lfsr_q;
        cnt_base    = frame_start ? '0 : cnt_q;
        mask_bit    = is_data & lfsr_cur[0];
        err         = ival & (((state == FRAME) & isop) | ((state == IDLE) & ~isop));
        lfsr_nxt    = lfsr_cur;
        cnt_nxt     = cnt_base;
        if (is_data) begin
            lfsr_nxt = {lfsr_cur[13:0], lfsr_cur[14] ^ lfsr_cur[13]};
            cnt_nxt  = (cnt_base == CMAX) ? CMAX : cnt_base + ONE;
        end
    end

    // LFSR and running data count
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_INIT;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    // Stage 1: register inputs, mask bit, error flag and end-of-frame count
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_i    <= '0;
            s1_q    <= '0;
            s1_idx  <= '0;
            s1_m    <= '0;
            s1_ss   <= '0;
            s1_sop  <= 1'b0;
            s1_val  <= 1'b0;
            s1_eop  <= 1'b0;
            s1_mask <= 1'b0;
            s1_err  <= 1'b0;
            s1_cnt  <= '0;
        end else begin
            s1_i    <= isubc_i;
            s1_q    <= isubc_q;
            s1_idx  <= iindex_subc;
            s1_m    <= index_M_in;
            s1_ss   <= index_SS_in;
            s1_sop  <= isop;
            s1_val  <= ival;
            s1_eop  <= ieop;
            s1_mask <= mask_bit;
            s1_err  <= err;
            // Count is captured only when a real frame ends; held otherwise.
            if (in_frame && ieop) s1_cnt <= cnt_nxt;
        end
    end

    // Stage 2: conditional saturating negate, forward everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            osubc_i      <= '0;
            osubc_q      <= '0;
            oindex_subc  <= '0;
            index_M_out  <= '0;
            index_SS_out <= '0;
            osop         <= 1'b0;
            oval         <= 1'b0;
            oeop         <= 1'b0;
            odata_cnt    <= '0;
            oframe_err   <= 1'b0;
        end else begin
            osubc_i      <= s1_mask ? sat_neg(s1_i) : s1_i;
            osubc_q      <= s1_mask ? sat_neg(s1_q) : s1_q;
            oindex_subc  <= s1_idx;
            index_M_out  <= s1_m;
            index_SS_out <= s1_ss;
            osop         <= s1_sop;
            oval         <= s1_val;
            oeop         <= s1_eop;
            odata_cnt    <= s1_cnt;
            oframe_err   <= s1_err;
        end
    end

endmodule
